otbn_pq_ctrlspr: RTL

- Register file and update engine for the PQ control SPRs: M, J2, J, Idx0, Idx1, Mode, X, Y.
- It is the responder end of the decoder's control-SPR and loop-step signals. It executes the ictrlspr read, write and read-set requests and the step strobes: sl_m, sl_j2, inc_j, inc_idx, set_idx, inc_x, inc_y.
- It sits beside the PQ ISPR block, feeds the NTT index and loop counters to the PQ ALU and WDR address logic, and feeds the lane coordinates to the Keccak unit.

---
 rtl/otbn_pq_ctrlspr_pkg.sv | 25 ++
 rtl/otbn_pq_ctrlspr_step.sv | 32 +++
 rtl/otbn_pq_ctrlspr.sv | 94 +++++++++
 3 files changed

// File: rtl/otbn_pq_ctrlspr_pkg.sv
// otbn_pq_ctrlspr_pkg: PQ control SPR addresses, step strobe bundle and Keccak lane limit
package otbn_pq_ctrlspr_pkg;
  typedef enum logic [7:0] {
    PQ_M    = 8'h00,
    PQ_J2   = 8'h01,
    PQ_J    = 8'h02,
    PQ_IDX0 = 8'h03,
    PQ_IDX1 = 8'h04,
    PQ_MODE = 8'h05,
    PQ_X    = 8'h06,
    PQ_Y    = 8'h07
  } pqctrlspr_e;

  typedef struct packed {
    logic sl_m;
    logic sl_j2;
    logic inc_j;
    logic inc_idx;
    logic set_idx;
    logic inc_x;
    logic inc_y;
  } ctrlspr_step_t;

  localparam logic [2:0] XyMax = 3'd4;
endpackage

// File: rtl/otbn_pq_ctrlspr_step.sv
// otbn_pq_ctrlspr_step: next-value logic for the loop-step strobes
module otbn_pq_ctrlspr_step
  import otbn_pq_ctrlspr_pkg::*;
#(
  parameter int PqLen = 32
) (
  input  ctrlspr_step_t    step,
  input  logic [PqLen-1:0] m,
  input  logic [PqLen-1:0] j2,
  input  logic [PqLen-1:0] j,
  input  logic [PqLen-1:0] idx0,
  input  logic [PqLen-1:0] idx1,
  input  logic [2:0]       x,
  input  logic [2:0]       y,
  output logic [PqLen-1:0] m_n,
  output logic [PqLen-1:0] j2_n,
  output logic [PqLen-1:0] j_n,
  output logic [PqLen-1:0] idx0_n,
  output logic [PqLen-1:0] idx1_n,
  output logic [2:0]       x_n,
  output logic [2:0]       y_n
);
  always_comb begin
    m_n    = step.sl_m  ? m << 1 : m;
    j2_n   = step.sl_j2 ? j2 >> 1 : j2;
    j_n    = step.inc_j ? j + PqLen'(1) : j;
    idx0_n = step.set_idx ? j : step.inc_idx ? idx0 + PqLen'(1) : idx0;
    idx1_n = step.set_idx ? j + j2 : step.inc_idx ? idx1 + PqLen'(1) : idx1;
    x_n    = step.inc_x ? ((x >= XyMax) ? 3'd0 : x + 3'd1) : x;
    y_n    = step.inc_y ? ((y >= XyMax) ? 3'd0 : y + 3'd1) : y;
  end
endmodule

// File: rtl/otbn_pq_ctrlspr.sv
// otbn_pq_ctrlspr: PQ control SPR file with software access and loop-step update engine
module otbn_pq_ctrlspr
  import otbn_pq_ctrlspr_pkg::*;
#(
  parameter int PqLen = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             state_reset_i,
  input  logic [7:0]       ctrlspr_addr_i,
  input  logic             ctrlspr_rd_i,
  input  logic             ctrlspr_wr_i,
  input  logic             ctrlspr_rs_i,
  input  logic [PqLen-1:0] ctrlspr_wdata_i,
  output logic [PqLen-1:0] ctrlspr_rdata_o,
  output logic             ctrlspr_rvalid_o,
  output logic             ctrlspr_err_o,
  input  logic             sl_m_i,
  input  logic             sl_j2_i,
  input  logic             inc_j_i,
  input  logic             inc_idx_i,
  input  logic             set_idx_i,
  input  logic             inc_x_i,
  input  logic             inc_y_i,
  output logic [PqLen-1:0] m_o,
  output logic [PqLen-1:0] j2_o,
  output logic [PqLen-1:0] j_o,
  output logic [PqLen-1:0] idx0_o,
  output logic [PqLen-1:0] idx1_o,
  output logic [PqLen-1:0] mode_o,
  output logic [2:0]       x_o,
  output logic [2:0]       y_o
);
  logic [1:0] nreq;
  logic multi, single, legal, sw_en;
  logic [7:0] sel;
  logic [7:0][PqLen-1:0] regs;
  logic [PqLen-1:0] cur, wv, m_n, j2_n, j_n, idx0_n, idx1_n;
  logic [2:0] x_n, y_n;
  ctrlspr_step_t step;

  assign nreq   = 2'(ctrlspr_rd_i) + 2'(ctrlspr_wr_i) + 2'(ctrlspr_rs_i);
  assign multi  = nreq > 2'd1;
  assign single = nreq == 2'd1;
  assign legal  = ctrlspr_addr_i <= PQ_Y;
  assign sw_en  = single && legal && !ctrlspr_rd_i;
  assign regs   = {PqLen'(y_o), PqLen'(x_o), mode_o, idx1_o, idx0_o, j_o, j2_o, m_o};
  assign cur    = regs[ctrlspr_addr_i[2:0]];
  assign wv     = ctrlspr_wr_i ? ctrlspr_wdata_i : cur | ctrlspr_wdata_i;
  // One-hot target of a software write; it overrides any strobe on that register only
  assign sel    = sw_en ? 8'b1 << ctrlspr_addr_i[2:0] : 8'b0;
  assign step   = '{sl_m: sl_m_i, sl_j2: sl_j2_i, inc_j: inc_j_i, inc_idx: inc_idx_i,
                    set_idx: set_idx_i, inc_x: inc_x_i, inc_y: inc_y_i};

  otbn_pq_ctrlspr_step #(.PqLen(PqLen)) u_step (
    .step   (step),
    .m      (m_o),
    .j2     (j2_o),
    .j      (j_o),
    .idx0   (idx0_o),
    .idx1   (idx1_o),
    .x      (x_o),
    .y      (y_o),
    .m_n    (m_n),
    .j2_n   (j2_n),
    .j_n    (j_n),
    .idx0_n (idx0_n),
    .idx1_n (idx1_n),
    .x_n    (x_n),
    .y_n    (y_n)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {m_o, j2_o, j_o, idx0_o, idx1_o, mode_o, x_o, y_o} <= '0;
      {ctrlspr_rdata_o, ctrlspr_rvalid_o, ctrlspr_err_o} <= '0;
    end else if (state_reset_i) begin
      {m_o, j2_o, j_o, idx0_o, idx1_o, mode_o, x_o, y_o} <= '0;
      {ctrlspr_rdata_o, ctrlspr_rvalid_o, ctrlspr_err_o} <= '0;
    end else begin
      m_o              <= sel[0] ? wv : m_n;
      j2_o             <= sel[1] ? wv : j2_n;
      j_o              <= sel[2] ? wv : j_n;
      idx0_o           <= sel[3] ? wv : idx0_n;
      idx1_o           <= sel[4] ? wv : idx1_n;
      mode_o           <= sel[5] ? wv : mode_o;
      x_o              <= sel[6] ? wv[2:0] : x_n;
      y_o              <= sel[7] ? wv[2:0] : y_n;
      ctrlspr_rdata_o  <= (single && legal && !ctrlspr_wr_i) ? cur : '0;
      ctrlspr_rvalid_o <= single && (!legal || !ctrlspr_wr_i);
      ctrlspr_err_o    <= multi || (single && !legal);
    end
  end
endmodule
